// File: rtl/if_fetch_stage.sv
// ============================================================================
// if_fetch_stage : MIPS IF stage - PC, imem req/ack port, skid buffer, redirect
// Revision 1.0
// ============================================================================
`default_nettype none

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] pc;
  logic [31:0] pending_pc;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;
  logic [31:0] target_pc;
  logic        ack_eff;
  logic        squash;
  logic        present_fetch;
  logic        present_skid;
  logic        bubble;
  logic        load_skid;
  logic        pc_inc;
  logic        pc_to_target;
  logic        pc_to_pending;
  logic [1:0]  unused_redirect_lsbs;

  assign target_pc            = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = redirect_pc[1:0];
  // An ack is only meaningful against a request we are actually driving.
  assign ack_eff              = imem_ack & imem_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH: begin
        if (redirect_valid)       state_next = ack_eff ? ST_FETCH : ST_FLUSH;
        else if (ack_eff && stall) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (redirect_valid || !stall) state_next = ST_FETCH;
      end
      ST_FLUSH: begin
        if (ack_eff) state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase
  end

  always_comb begin
    imem_req      = (state != ST_HOLD) && !rst;
    imem_addr     = pc;
    squash        = 1'b0;
    present_fetch = 1'b0;
    present_skid  = 1'b0;
    bubble        = 1'b0;
    load_skid     = 1'b0;
    pc_inc        = 1'b0;
    pc_to_target  = 1'b0;
    pc_to_pending = 1'b0;
    if (redirect_valid) begin
      squash       = 1'b1;
      pc_to_target = (state == ST_HOLD) || ack_eff;
    end else begin
      case (state)
        ST_FETCH: begin
          if (ack_eff) begin
            pc_inc        = 1'b1;
            load_skid     = stall;
            present_fetch = !stall;
          end else begin
            bubble = !stall;
          end
        end
        ST_HOLD:  present_skid  = !stall;
        ST_FLUSH: pc_to_pending = ack_eff;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      pending_pc <= RESET_PC;
      skid_pc    <= 32'h0;
      skid_inst  <= 32'h0;
      if_pc      <= 32'h0;
      if_inst    <= 32'h0;
      if_valid   <= 1'b0;
    end else begin
      if (squash) begin
        if_valid   <= 1'b0;
        if_inst    <= 32'h0;
        pending_pc <= target_pc;
      end
      if (present_fetch) begin
        if_pc    <= pc;
        if_inst  <= imem_rdata;
        if_valid <= 1'b1;
      end
      if (present_skid) begin
        if_pc    <= skid_pc;
        if_inst  <= skid_inst;
        if_valid <= 1'b1;
      end
      if (bubble) begin
        if_valid <= 1'b0;
        if_inst  <= 32'h0;
      end
      if (load_skid) begin
        skid_pc   <= pc;
        skid_inst <= imem_rdata;
      end
      if (pc_to_target)       pc <= target_pc;
      else if (pc_inc)        pc <= pc + 32'd4;
      else if (pc_to_pending) pc <= pending_pc;
    end
  end

endmodule

`default_nettype wire
